mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 114 +++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests over a request/ready bus,
// stalls the front of the pipeline while an access is in flight, forwards
// WB-stage results into store data, and owns the MEM/WB pipeline register.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MEMWBop,
  input  logic [31:0] EXMEM_ALUout,
  input  logic        EXMEM_RegWrite,
  input  logic [4:0]  EXMEM_WriteRegAddr,
  input  logic        EXMEM_MemtoReg,
  input  logic        EXMEM_MemWrite,
  input  logic        EXMEM_MemRead,
  input  logic [31:0] EXMEM_MemWriteData,
  input  logic [4:0]  EXMEM_rt,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteRegAddr,
  input  logic [31:0] WB_RegWriteData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        MemStall,
  output logic        AlignErr,
  output logic        MEMWB_RegWrite,
  output logic [4:0]  MEMWB_WriteRegAddr,
  output logic [31:0] MEMWB_RegWriteData
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        access;
  logic        misaligned;
  logic        stall_raw;
  logic        align_raw;
  logic        fwd_hit;
  logic [31:0] store_data;

  assign access     = EXMEM_MemRead | EXMEM_MemWrite;
  assign misaligned = access & (EXMEM_ALUout[1:0] != 2'b00);
  assign stall_raw  = ((state == IDLE) & access & ~misaligned) | (state == REQ);
  assign align_raw  = (state == IDLE) & misaligned;

  // Status outputs are forced low while reset is held, even though the
  // inputs may describe an access.
  assign MemStall = reset & stall_raw;
  assign AlignErr = reset & align_raw;

  // A store whose source register is being written back this very cycle
  // must take the WB value; r0 is never forwarded.
  assign fwd_hit    = WB_RegWrite & (WB_WriteRegAddr == EXMEM_rt) & (EXMEM_rt != 5'd0);
  assign store_data = fwd_hit ? WB_RegWriteData : EXMEM_MemWriteData;

  // Access FSM and registered memory bus; request fields stay frozen from
  // issue until ready is seen, and an issued request is never aborted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !misaligned) begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= EXMEM_MemWrite;
            dmem_addr  <= {EXMEM_ALUout[31:2], 2'b00};
            dmem_wdata <= store_data;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            rdata_q  <= dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (MEMWBop == 2'd0 || MEMWBop == 2'd1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: bubbles while stalled or on a misaligned access,
  // otherwise follows the pipeline control op (advance/bubble/hold).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEMWB_RegWrite     <= 1'b0;
      MEMWB_WriteRegAddr <= 5'd0;
      MEMWB_RegWriteData <= 32'd0;
    end else if (stall_raw || align_raw || MEMWBop == 2'd1) begin
      MEMWB_RegWrite     <= 1'b0;
      MEMWB_WriteRegAddr <= 5'd0;
      MEMWB_RegWriteData <= 32'd0;
    end else if (MEMWBop == 2'd0) begin
      MEMWB_RegWrite     <= EXMEM_RegWrite;
      MEMWB_WriteRegAddr <= EXMEM_WriteRegAddr;
      MEMWB_RegWriteData <= EXMEM_MemtoReg ? rdata_q : EXMEM_ALUout;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized instruction
// sequences, checked cycle by cycle against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  MEMWBop;
  logic [31:0] EXMEM_ALUout;
  logic        EXMEM_RegWrite;
  logic [4:0]  EXMEM_WriteRegAddr;
  logic        EXMEM_MemtoReg;
  logic        EXMEM_MemWrite;
  logic        EXMEM_MemRead;
  logic [31:0] EXMEM_MemWriteData;
  logic [4:0]  EXMEM_rt;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteRegAddr;
  logic [31:0] WB_RegWriteData;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        MemStall;
  logic        AlignErr;
  logic        MEMWB_RegWrite;
  logic [4:0]  MEMWB_WriteRegAddr;
  logic [31:0] MEMWB_RegWriteData;

  int n_pass  = 0;
  int n_total = 0;

  // Expected MEM/WB contents
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .MEMWBop(MEMWBop),
    .EXMEM_ALUout(EXMEM_ALUout), .EXMEM_RegWrite(EXMEM_RegWrite),
    .EXMEM_WriteRegAddr(EXMEM_WriteRegAddr), .EXMEM_MemtoReg(EXMEM_MemtoReg),
    .EXMEM_MemWrite(EXMEM_MemWrite), .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_MemWriteData(EXMEM_MemWriteData), .EXMEM_rt(EXMEM_rt),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegAddr(WB_WriteRegAddr),
    .WB_RegWriteData(WB_RegWriteData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .MemStall(MemStall), .AlignErr(AlignErr),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_WriteRegAddr(MEMWB_WriteRegAddr),
    .MEMWB_RegWriteData(MEMWB_RegWriteData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_memwb(input string tag);
    chk({tag, ".MEMWB_RegWrite"}, {31'd0, MEMWB_RegWrite}, {31'd0, m_rw});
    chk({tag, ".MEMWB_WriteRegAddr"}, {27'd0, MEMWB_WriteRegAddr}, {27'd0, m_wa});
    chk({tag, ".MEMWB_RegWriteData"}, MEMWB_RegWriteData, m_wd);
  endtask

  task automatic model_bubble();
    m_rw = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
  endtask

  task automatic set_ex(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic rw, input logic [4:0] wa, input logic m2r,
                        input logic [31:0] wdat, input logic [4:0] rt);
    EXMEM_MemRead = rd; EXMEM_MemWrite = wr; EXMEM_ALUout = alu;
    EXMEM_RegWrite = rw; EXMEM_WriteRegAddr = wa; EXMEM_MemtoReg = m2r;
    EXMEM_MemWriteData = wdat; EXMEM_rt = rt;
  endtask

  // Non-memory instruction: no stall, MEM/WB follows op on the next edge
  task automatic do_alu(input string tag, input logic [31:0] alu, input logic rw,
                        input logic [4:0] wa, input logic [1:0] op);
    @(negedge clk);
    chk_memwb({tag, ".prev"});
    set_ex(1'b0, 1'b0, alu, rw, wa, 1'b0, $urandom, 5'($urandom));
    MEMWBop = op; dmem_ready = 1'b0;
    #1;
    chk({tag, ".MemStall"}, {31'd0, MemStall}, 32'd0);
    chk({tag, ".AlignErr"}, {31'd0, AlignErr}, 32'd0);
    chk({tag, ".dmem_req"}, {31'd0, dmem_req}, 32'd0);
    if (op == 2'd0) begin
      m_rw = rw; m_wa = wa; m_wd = alu;
    end else if (op == 2'd1) begin
      model_bubble();
    end
    $display("alu   %s alu=%h rw=%0d wa=%0d op=%0d", tag, alu, rw, wa, op);
  endtask

  // Misaligned access: one-cycle AlignErr, no request, bubble into MEM/WB
  task automatic do_misaligned(input string tag, input logic wr, input logic [31:0] alu);
    @(negedge clk);
    chk_memwb({tag, ".prev"});
    set_ex(~wr, wr, alu, ~wr, 5'($urandom), ~wr, $urandom, 5'($urandom));
    MEMWBop = 2'($urandom); dmem_ready = 1'b0;
    #1;
    chk({tag, ".AlignErr"}, {31'd0, AlignErr}, 32'd1);
    chk({tag, ".MemStall"}, {31'd0, MemStall}, 32'd0);
    chk({tag, ".dmem_req"}, {31'd0, dmem_req}, 32'd0);
    model_bubble();
    $display("misal %s alu=%h we=%0d", tag, alu, wr);
  endtask

  // Aligned load/store through the full handshake. rst_at >= 0 asserts
  // reset during that REQ cycle and abandons the access.
  task automatic do_access(input string tag, input logic wr, input logic [31:0] alu,
                           input logic rw, input logic [4:0] wa, input logic m2r,
                           input logic [31:0] wdat, input logic [4:0] rt,
                           input logic wb_rw, input logic [4:0] wb_a, input logic [31:0] wb_d,
                           input int delay, input logic [31:0] rdat,
                           input int nhold, input logic [1:0] fop, input int rst_at);
    logic [31:0] e_addr, e_wdata;
    int stalls;
    stalls = 0;
    // IDLE detect cycle
    @(negedge clk);
    chk_memwb({tag, ".prev"});
    set_ex(~wr, wr, alu, rw, wa, m2r, wdat, rt);
    WB_RegWrite = wb_rw; WB_WriteRegAddr = wb_a; WB_RegWriteData = wb_d;
    MEMWBop = 2'($urandom); dmem_ready = 1'b0;
    #1;
    chk({tag, ".idle.dmem_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, ".idle.AlignErr"}, {31'd0, AlignErr}, 32'd0);
    if (MemStall === 1'b1) stalls++;
    e_addr  = alu & 32'hFFFF_FFFC;
    e_wdata = (wb_rw && wb_a == rt && rt != 5'd0) ? wb_d : wdat;
    model_bubble();
    // REQ cycles
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk);
      chk_memwb($sformatf("%s.req%0d", tag, k));
      WB_RegWrite = 1'($urandom); WB_WriteRegAddr = 5'($urandom); WB_RegWriteData = $urandom;
      MEMWBop = 2'($urandom);
      dmem_ready = (k == delay);
      dmem_rdata = (k == delay) ? rdat : $urandom;
      #1;
      chk($sformatf("%s.req%0d.dmem_req", tag, k), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("%s.req%0d.dmem_addr", tag, k), dmem_addr, e_addr);
      chk($sformatf("%s.req%0d.dmem_we", tag, k), {31'd0, dmem_we}, {31'd0, wr});
      chk($sformatf("%s.req%0d.dmem_wdata", tag, k), dmem_wdata, e_wdata);
      if (MemStall === 1'b1) stalls++;
      if (k == rst_at) begin
        #2 reset = 1'b0;
        #1;
        chk({tag, ".rst.dmem_req"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, ".rst.MemStall"}, {31'd0, MemStall}, 32'd0);
        chk({tag, ".rst.AlignErr"}, {31'd0, AlignErr}, 32'd0);
        model_bubble();
        chk_memwb({tag, ".rst"});
        set_ex(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0);
        dmem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("reset %s asserted during REQ cycle %0d", tag, k);
        return;
      end
    end
    // DONE: optional hold cycles, then advance or bubble
    for (int h = 0; h <= nhold; h++) begin
      @(negedge clk);
      chk_memwb($sformatf("%s.done%0d", tag, h));
      MEMWBop = (h == nhold) ? fop : 2'd2 + 2'($urandom % 2);
      dmem_ready = 1'b0; dmem_rdata = $urandom;
      #1;
      chk($sformatf("%s.done%0d.dmem_req", tag, h), {31'd0, dmem_req}, 32'd0);
      chk($sformatf("%s.done%0d.MemStall", tag, h), {31'd0, MemStall}, 32'd0);
    end
    chk({tag, ".stall_cycles"}, stalls, delay + 2);
    if (fop == 2'd0) begin
      m_rw = rw; m_wa = wa; m_wd = m2r ? rdat : alu;
    end else begin
      model_bubble();
    end
    $display("%s %s addr=%h wdata=%h delay=%0d hold=%0d op=%0d stalls=%0d",
             wr ? "store" : "load ", tag, e_addr, e_wdata, delay, nhold, fop, stalls);
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    // Reset with a misaligned access presented: status must stay low
    reset = 1'b0; MEMWBop = 2'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    WB_RegWrite = 1'b0; WB_WriteRegAddr = 5'd0; WB_RegWriteData = 32'd0;
    set_ex(1'b1, 1'b0, 32'h2, 1'b1, 5'd1, 1'b1, 32'd0, 5'd0);
    model_bubble();
    #1;
    chk("reset.AlignErr", {31'd0, AlignErr}, 32'd0);
    chk("reset.MemStall", {31'd0, MemStall}, 32'd0);
    chk("reset.dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset.dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("reset.dmem_addr", dmem_addr, 32'd0);
    chk("reset.dmem_wdata", dmem_wdata, 32'd0);
    chk_memwb("reset");
    set_ex(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    $display("reset released");

    // Directed scenarios
    do_access("load_basic", 1'b0, 32'h100, 1'b1, 5'd9, 1'b1, 32'd0, 5'd0,
              1'b0, 5'd0, 32'd0, 0, 32'hDEADBEEF, 0, 2'd0, -1);
    do_access("store_fwd", 1'b1, 32'h204, 1'b0, 5'd0, 1'b0, 32'hAAAA, 5'd5,
              1'b1, 5'd5, 32'h1234, 0, 32'h0, 0, 2'd0, -1);
    do_access("store_r0", 1'b1, 32'h208, 1'b0, 5'd0, 1'b0, 32'hBBBB, 5'd0,
              1'b1, 5'd0, 32'h5678, 1, 32'h0, 0, 2'd0, -1);
    do_access("load_slow", 1'b0, 32'h300, 1'b1, 5'd7, 1'b1, 32'd0, 5'd0,
              1'b0, 5'd0, 32'd0, 3, 32'hCAFEF00D, 2, 2'd0, -1);
    do_access("load_bubble", 1'b0, 32'h400, 1'b1, 5'd8, 1'b1, 32'd0, 5'd0,
              1'b0, 5'd0, 32'd0, 1, 32'h11112222, 1, 2'd1, -1);
    do_alu("alu_basic", 32'h55, 1'b1, 5'd3, 2'd0);
    do_alu("alu_hold", 32'h66, 1'b1, 5'd4, 2'd3);
    do_alu("alu_bubble", 32'h77, 1'b1, 5'd4, 2'd1);
    do_misaligned("misal_load", 1'b0, 32'h102);
    do_alu("after_misal", 32'h88, 1'b1, 5'd6, 2'd0);
    do_access("load_rst", 1'b0, 32'h500, 1'b1, 5'd10, 1'b1, 32'd0, 5'd0,
              1'b0, 5'd0, 32'd0, 4, 32'h99999999, 0, 2'd0, 1);
    do_alu("post_rst", 32'h99, 1'b1, 5'd11, 2'd0);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      kind = $urandom % 4;
      a = $urandom;
      case (kind)
        0: do_alu($sformatf("r%0d", i), a, 1'($urandom), 5'($urandom), 2'($urandom));
        1: do_access($sformatf("r%0d", i), 1'b0, a & 32'hFFFF_FFFC, 1'($urandom),
                     5'($urandom), 1'($urandom), $urandom, 5'($urandom),
                     1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 4),
                     $urandom, $urandom_range(0, 2), 2'($urandom % 2), -1);
        2: begin
          logic [4:0] rt;
          rt = 5'($urandom);
          do_access($sformatf("r%0d", i), 1'b1, a & 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b0,
                    $urandom, rt, 1'($urandom), ($urandom % 2) ? rt : 5'($urandom),
                    $urandom, $urandom_range(0, 4), $urandom, $urandom_range(0, 2),
                    2'($urandom % 2), -1);
        end
        default: do_misaligned($sformatf("r%0d", i), 1'($urandom), a | 32'd1 + 32'(($urandom % 2)));
      endcase
    end
    @(negedge clk);
    chk_memwb("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
